// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: requester, FIFO and debug signals of the FIFO write arbiter.
interface fifo_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              req0_write;
    logic [DATA_W-1:0] req0_writedata;
    logic              req0_waitrequest;
    logic              req1_write;
    logic [DATA_W-1:0] req1_writedata;
    logic              req1_waitrequest;
    logic              fifo_write;
    logic [DATA_W-1:0] fifo_writedata;
    logic              fifo_full;
    logic [1:0]        grant;
    logic [CNT_W-1:0]  word_count0;
    logic [CNT_W-1:0]  word_count1;
    modport master (
        output req0_write, req0_writedata, req1_write, req1_writedata, fifo_full,
        input  req0_waitrequest, req1_waitrequest, fifo_write, fifo_writedata,
               grant, word_count0, word_count1
    );
    modport slave (
        input  req0_write, req0_writedata, req1_write, req1_writedata, fifo_full,
        output req0_waitrequest, req1_waitrequest, fifo_write, fifo_writedata,
               grant, word_count0, word_count1
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-bounded sharing of one FIFO write port between two Avalon-MM writers.
module fifo_write_arbiter #(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input logic wrclock,
    input logic reset,
    fifo_write_arbiter_if.slave bus
);
    localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
    state_t           state;
    logic [BW-1:0]    burst_cnt;
    logic             last_served;
    logic [CNT_W-1:0] word_count0;
    logic [CNT_W-1:0] word_count1;
    logic             g0, g1, cur_write, other_write, accept, burst_end;
    assign g0          = state == GRANT0;
    assign g1          = state == GRANT1;
    assign cur_write   = g1 ? bus.req1_write : bus.req0_write;
    assign other_write = g1 ? bus.req0_write : bus.req1_write;
    // Reset also masks the handshake so an in-flight word is neither written nor acknowledged.
    assign accept      = (g0 | g1) & cur_write & !bus.fifo_full & !reset;
    assign burst_end   = burst_cnt == BW'(MAX_BURST - 1);
    assign bus.req0_waitrequest = reset | !g0 | bus.fifo_full;
    assign bus.req1_waitrequest = reset | !g1 | bus.fifo_full;
    assign bus.fifo_write       = accept;
    assign bus.fifo_writedata   = g0 ? bus.req0_writedata : g1 ? bus.req1_writedata : '0;
    assign bus.grant            = {g1, g0};
    assign bus.word_count0      = word_count0;
    assign bus.word_count1      = word_count1;
    always_ff @(posedge wrclock) begin
        if (reset) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            last_served <= 1'b1;
            word_count0 <= '0;
            word_count1 <= '0;
        end else if (state == IDLE) begin
            if (bus.req0_write & (!bus.req1_write | last_served)) state <= GRANT0;
            else if (bus.req1_write) state <= GRANT1;
        end else if (!cur_write) begin
            state       <= other_write ? (g0 ? GRANT1 : GRANT0) : IDLE;
            burst_cnt   <= '0;
            last_served <= g1;
        end else if (accept) begin
            word_count0 <= word_count0 + CNT_W'(g0);
            word_count1 <= word_count1 + CNT_W'(g1);
            burst_cnt   <= burst_end ? '0 : burst_cnt + 1'b1;
            // Hand over only at a burst boundary; a stalled grant is never taken away.
            if (burst_end && other_write) begin
                state       <= g0 ? GRANT1 : GRANT0;
                last_served <= g1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: requester models feed per-source expected-word queues; a negedge monitor scores FIFO writes.
module tb_fifo_write_arbiter;
    localparam int DATA_W = 32, MAX_BURST = 4, CNT_W = 4;
    logic wrclock = 1'b0;
    logic reset = 1'b1;
    always #5 wrclock = ~wrclock;
    fifo_write_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
    fifo_write_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
        .wrclock(wrclock), .reset(reset), .bus(bus)
    );
    int checks = 0, errors = 0;
    int left[2], rate[2];
    logic pres[2], acc[2];
    logic [DATA_W-1:0] dat[2], nxt[2];
    logic [DATA_W-1:0] exp0[$], exp1[$];
    int src_log[$], wcyc[$];
    logic [CNT_W-1:0] mcnt0 = '0, mcnt1 = '0;
    int cyc = 0, run_len = 0, run_src = 0;
    int full_pct = 0, stall_at = -1, stall_left = 0;
    logic rst_req = 1'b1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask
    // Monitor: every accepted word must be the oldest unaccepted word of the granted requester.
    always @(negedge wrclock) begin
        logic src, other_w;
        acc[0] = bus.req0_write & !bus.req0_waitrequest;
        acc[1] = bus.req1_write & !bus.req1_waitrequest;
        chk("word_count0", 32'(bus.word_count0), 32'(mcnt0));
        chk("word_count1", 32'(bus.word_count1), 32'(mcnt1));
        if (reset) begin
            chk("write_in_reset", 32'(bus.fifo_write), 0);
            mcnt0 = '0; mcnt1 = '0; run_len = 0;
        end else if (bus.fifo_write === 1'b1) begin
            chk("write_while_full", 32'(bus.fifo_full), 0);
            chk("grant_onehot", 32'(bus.grant == 2'b01 || bus.grant == 2'b10), 1);
            src = bus.grant[1];
            if ((src ? exp1.size() : exp0.size()) == 0) begin
                checks++; errors++;
                $display("FAIL extra_write src %0d data %h expected none", src, bus.fifo_writedata);
            end else chk(src ? "data1" : "data0", bus.fifo_writedata, src ? exp1.pop_front() : exp0.pop_front());
            if (src) mcnt1 = mcnt1 + 1'b1; else mcnt0 = mcnt0 + 1'b1;
            src_log.push_back(int'(src));
            wcyc.push_back(cyc);
            other_w = src ? bus.req0_write : bus.req1_write;
            if (int'(src) != run_src || !other_w) run_len = 0;
            run_src = int'(src);
            if (other_w) begin
                run_len++;
                chk("burst_bound", 32'(run_len <= MAX_BURST), 1);
            end
        end
        cyc++;
    end
    task automatic step();
        logic ff;
        @(posedge wrclock); #1;
        reset = rst_req;
        if (stall_at == src_log.size()) begin stall_left = 3; stall_at = -1; end
        ff = stall_left > 0 ? 1'b1 : ($urandom_range(99) < full_pct);
        if (stall_left > 0) stall_left--;
        for (int n = 0; n < 2; n++) begin
            if (pres[n] && acc[n]) pres[n] = 1'b0;
            if (!pres[n] && left[n] > 0 && $urandom_range(99) < rate[n]) begin
                pres[n] = 1'b1; dat[n] = nxt[n]; nxt[n]++; left[n]--;
                if (n == 0) exp0.push_back(dat[n]); else exp1.push_back(dat[n]);
            end
        end
        bus.req0_write = pres[0]; bus.req0_writedata = dat[0];
        bus.req1_write = pres[1]; bus.req1_writedata = dat[1];
        bus.fifo_full  = ff;
    endtask
    function automatic logic idle();
        return left[0] == 0 && left[1] == 0 && !pres[0] && !pres[1];
    endfunction
    task automatic run_idle(input int max);
        int i = 0;
        while (!idle() && i < max) begin step(); i++; end
        step(); step();
        chk("drain_timeout", 32'(idle()), 1);
    endtask
    task automatic do_reset();
        rst_req = 1'b1; step(); step();
        rst_req = 1'b0; step();
        src_log.delete(); wcyc.delete();
    endtask
    initial begin
        int i;
        for (int n = 0; n < 2; n++) begin left[n] = 0; rate[n] = 100; pres[n] = 1'b0; acc[n] = 1'b0; dat[n] = '0; end
        nxt[0] = 32'h0100_0000; nxt[1] = 32'h0200_0000;
        bus.req0_write = 1'b0; bus.req0_writedata = '0;
        bus.req1_write = 1'b0; bus.req1_writedata = '0;
        bus.fifo_full = 1'b0;
        // Reset held with both requesters writing; requester 0 wins the first tie.
        left[0] = 1; left[1] = 1;
        step(); step();
        @(negedge wrclock);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_fifo_write", 32'(bus.fifo_write), 0);
        chk("rst_wait0", 32'(bus.req0_waitrequest), 1);
        chk("rst_wait1", 32'(bus.req1_waitrequest), 1);
        rst_req = 1'b0; step(); step();
        @(negedge wrclock);
        chk("first_grant", 32'(bus.grant), 32'h1);
        run_idle(100);
        // Requester 0 alone: 0x80..0x85 back to back.
        do_reset();
        nxt[0] = 32'h80; left[0] = 6;
        step(); step();
        @(negedge wrclock);
        chk("solo_grant", 32'(bus.grant), 32'h1);
        run_idle(100);
        @(negedge wrclock);
        chk("solo_words", src_log.size(), 6);
        if (wcyc.size() == 6) chk("solo_no_bubble", wcyc[5] - wcyc[0], 5);
        chk("solo_idle", 32'(bus.grant), 0);
        chk("solo_count0", 32'(bus.word_count0), 6);
        // Both saturated: alternating bursts of MAX_BURST with no bubbles.
        do_reset();
        left[0] = 12; left[1] = 12;
        i = 0;
        while (src_log.size() < 12 && i < 200) begin step(); i++; end
        chk("rr_reached", 32'(src_log.size() >= 12), 1);
        if (src_log.size() >= 12) begin
            for (int k = 0; k < 12; k++) chk("rr_order", src_log[k], (k / MAX_BURST) % 2);
            chk("rr_no_bubble", wcyc[11] - wcyc[0], 11);
        end
        run_idle(200);
        // FIFO full for three cycles after requester 0's second word.
        do_reset();
        left[0] = 4; left[1] = 2; stall_at = 2;
        i = 0;
        while (src_log.size() < 2 && i < 100) begin step(); i++; end
        for (int k = 0; k < 3; k++) begin
            @(negedge wrclock);
            chk("stall_wait0", 32'(bus.req0_waitrequest), 1);
            chk("stall_write", 32'(bus.fifo_write), 0);
            chk("stall_grant", 32'(bus.grant), 32'h1);
            chk("stall_data", bus.fifo_writedata, exp0.size() > 0 ? exp0[0] : 32'hx);
            chk("stall_count0", 32'(bus.word_count0), 2);
            step();
        end
        run_idle(100);
        @(negedge wrclock);
        chk("stall_words", src_log.size(), 6);
        if (src_log.size() == 6) begin
            for (int k = 0; k < 4; k++) chk("stall_src0", src_log[k], 0);
            chk("stall_then_req1", src_log[4], 1);
        end
        chk("stall_count0_end", 32'(bus.word_count0), 4);
        // Reset in the middle of a requester 1 burst; the held word is written exactly once.
        do_reset();
        left[1] = 4;
        i = 0;
        while (src_log.size() < 2 && i < 100) begin step(); i++; end
        rst_req = 1'b1; reset = 1'b1;
        @(negedge wrclock);
        chk("mid_rst_write", 32'(bus.fifo_write), 0);
        chk("mid_rst_wait1", 32'(bus.req1_waitrequest), 1);
        step();
        @(negedge wrclock);
        chk("mid_rst_grant", 32'(bus.grant), 0);
        chk("mid_rst_count1", 32'(bus.word_count1), 0);
        rst_req = 1'b0;
        run_idle(100);
        @(negedge wrclock);
        chk("mid_rst_words", src_log.size(), 4);
        chk("mid_rst_count1_end", 32'(bus.word_count1), 2);
        // 17 words through a 4-bit counter wrap to 1.
        do_reset();
        left[1] = 17;
        run_idle(200);
        @(negedge wrclock);
        chk("wrap_count1", 32'(bus.word_count1), 1);
        // Randomised traffic and back-pressure.
        do_reset();
        for (int r = 0; r < 30; r++) begin
            left[0] = $urandom_range(20); left[1] = $urandom_range(20);
            rate[0] = $urandom_range(100, 20); rate[1] = $urandom_range(100, 20);
            full_pct = $urandom_range(40);
            run_idle(3000);
        end
        full_pct = 0;
        chk("leftover0", exp0.size(), 0);
        chk("leftover1", exp1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
